x_top_uart_link: RTL and testbench

Parametrised full-duplex UART link: a serialiser and deserialiser with configurable data width, TX and RX FIFOs, and an internal loopback mode. Sits between the bus-side peripheral logic and the chip pads. It replaces fixed 8-bit back-to-back TX/RX pairing with a buffered, error-reporting link. Loopback gives the back-to-back self-test path without external wiring.

---
 rtl/x_top_uart_link.sv | 236 +++++++++++++++++++++++
 tb/tb_x_top_uart_link.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/x_top_uart_link.sv
// Buffered full-duplex UART link with TX/RX FIFOs, error reporting and internal loopback.
// Even parity is inserted and checked when X_TOP_UART_LINK_PARITY_EN is defined.
module x_top_uart_link #(
  parameter int unsigned p_clk_hz    = 1000000,
  parameter int unsigned p_baud      = 9600,
  parameter int unsigned p_data_bits = 8,
  parameter int unsigned p_tx_depth  = 4,
  parameter int unsigned p_rx_depth  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [p_data_bits-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_accept,
  output logic [p_data_bits-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_accept,
  input  logic                   i_rx,
  output logic                   o_tx,
  input  logic                   i_loopback,
  output logic                   o_busy,
  output logic                   o_rx_overrun,
  output logic                   o_frame_err,
  output logic                   o_parity_err
);
  localparam int unsigned Div = p_clk_hz / p_baud;
  localparam int unsigned Cw  = $clog2(Div) + 1;
  localparam int unsigned Taw = $clog2(p_tx_depth);
  localparam int unsigned Raw = $clog2(p_rx_depth);
  localparam logic [Cw-1:0] DivLast  = Cw'(Div - 1);
  localparam logic [Cw-1:0] HalfLast = Cw'(Div / 2 - 1);
  localparam logic [3:0]    BitLast  = 4'(p_data_bits - 1);
  localparam logic [Taw:0]  TxFull   = p_tx_depth[Taw:0];
  localparam logic [Raw:0]  RxFull   = p_rx_depth[Raw:0];
`ifdef X_TOP_UART_LINK_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------- TX ----------------
  logic [p_data_bits-1:0] tx_mem [p_tx_depth];
  logic [Taw-1:0]         tx_wr_q, tx_rd_q;
  logic [Taw:0]           tx_cnt_q;
  logic                   tx_push, tx_pop, tx_div_end, tx_line;
  logic [p_data_bits-1:0] tx_head, tx_shift_q;
  state_e                 tx_state_q;
  logic [Cw-1:0]          tx_div_q;
  logic [3:0]             tx_bit_q;
  logic                   tx_par_q, tx_line_q, tx_q;

  assign o_accept   = (tx_cnt_q != TxFull);
  assign tx_push    = i_valid & o_accept;
  assign tx_div_end = (tx_div_q == DivLast);
  assign tx_head    = tx_mem[tx_rd_q];
  // Pop from IDLE, or at the end of STOP so frames run back to back.
  assign tx_pop     = (tx_cnt_q != '0) &&
                      ((tx_state_q == StIdle) || ((tx_state_q == StStop) && tx_div_end));
  assign o_busy     = (tx_cnt_q != '0) || (tx_state_q != StIdle);
  assign o_tx       = tx_q;

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  always_comb begin
    case (tx_state_q)
      StStart:  tx_line = 1'b0;
      StData:   tx_line = tx_shift_q[0];
      StParity: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= StIdle;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_q       <= 1'b1;
    end else begin
      tx_line_q <= tx_line;
      tx_q      <= tx_line | i_loopback;
      tx_div_q  <= tx_div_end ? '0 : tx_div_q + 1'b1;
      case (tx_state_q)
        StIdle: begin
          tx_div_q <= '0;
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_par_q   <= ^tx_head;
            tx_state_q <= StStart;
          end
        end
        StStart: if (tx_div_end) begin
          tx_bit_q   <= '0;
          tx_state_q <= StData;
        end
        StData: if (tx_div_end) begin
          tx_shift_q <= tx_shift_q >> 1;
          tx_bit_q   <= tx_bit_q + 1'b1;
          if (tx_bit_q == BitLast) tx_state_q <= ParityEn ? StParity : StStop;
        end
        StParity: if (tx_div_end) tx_state_q <= StStop;
        StStop: if (tx_div_end) begin
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_par_q   <= ^tx_head;
            tx_state_q <= StStart;
          end else begin
            tx_state_q <= StIdle;
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [p_data_bits-1:0] rx_mem [p_rx_depth];
  logic [Raw-1:0]         rx_wr_q, rx_rd_q;
  logic [Raw:0]           rx_cnt_q;
  logic [1:0]             rx_sync_q;
  logic                   rx_line, rx_prev_q, rx_div_end, rx_stop_hit;
  logic                   rx_par_bad, rx_full, rx_pop, rx_write;
  state_e                 rx_state_q;
  logic [Cw-1:0]          rx_div_q;
  logic [3:0]             rx_bit_q;
  logic [p_data_bits-1:0] rx_shift_q;
  logic                   rx_par_q, rx_frame_q, rx_par_err_q, rx_ovr_q;

  assign rx_line      = rx_sync_q[1];
  assign rx_div_end   = (rx_div_q == DivLast);
  assign rx_stop_hit  = (rx_state_q == StStop) && rx_div_end;
  assign rx_par_bad   = ParityEn && ((^rx_shift_q) != rx_par_q);
  assign rx_full      = (rx_cnt_q == RxFull);
  assign o_valid      = (rx_cnt_q != '0);
  assign rx_pop       = o_valid & i_accept;
  assign rx_write     = rx_stop_hit && rx_line && !rx_par_bad && (!rx_full || rx_pop);
  assign o_data       = o_valid ? rx_mem[rx_rd_q] : '0;
  assign o_frame_err  = rx_frame_q;
  assign o_parity_err = rx_par_err_q;
  assign o_rx_overrun = rx_ovr_q;

  // Loopback joins ahead of the synchroniser so both paths see identical timing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], i_loopback ? tx_line_q : i_rx};
      rx_prev_q <= rx_line;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_write) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_write) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)   rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_write && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_write && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q   <= StIdle;
      rx_div_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      rx_frame_q   <= 1'b0;
      rx_par_err_q <= 1'b0;
      rx_ovr_q     <= 1'b0;
    end else begin
      rx_frame_q   <= 1'b0;
      rx_par_err_q <= 1'b0;
      rx_ovr_q     <= 1'b0;
      rx_div_q     <= rx_div_end ? '0 : rx_div_q + 1'b1;
      case (rx_state_q)
        // A falling edge needs a preceding 1, so a stuck-low line cannot re-arm.
        StIdle: begin
          rx_div_q <= '0;
          if (rx_prev_q && !rx_line) rx_state_q <= StStart;
        end
        StStart: if (rx_div_q == HalfLast) begin
          rx_div_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_line ? StIdle : StData;
        end
        StData: if (rx_div_end) begin
          rx_shift_q <= {rx_line, rx_shift_q[p_data_bits-1:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == BitLast) rx_state_q <= ParityEn ? StParity : StStop;
        end
        StParity: if (rx_div_end) begin
          rx_par_q   <= rx_line;
          rx_state_q <= StStop;
        end
        StStop: if (rx_div_end) begin
          rx_state_q   <= StIdle;
          rx_frame_q   <= !rx_line;
          rx_par_err_q <= rx_line && rx_par_bad;
          rx_ovr_q     <= rx_line && !rx_par_bad && rx_full && !rx_pop;
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_x_top_uart_link.sv
// Scoreboard bench for x_top_uart_link at DIV=10, 8 data bits, depth-4 FIFOs.
module tb_x_top_uart_link;
  localparam int unsigned Div = 10;
`ifdef X_TOP_UART_LINK_PARITY_EN
  localparam int unsigned Pbit = 1;
`else
  localparam int unsigned Pbit = 0;
`endif
  localparam int unsigned Frame = (10 + Pbit) * Div;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_accept = 1'b1;
  logic       i_loopback = 1'b0;
  logic       ext_loop = 1'b0;
  logic       rx_drv = 1'b1;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_accept, o_valid, o_tx, o_busy, o_rx_overrun, o_frame_err, o_parity_err;

  assign i_rx = ext_loop ? o_tx : rx_drv;

  x_top_uart_link #(
    .p_clk_hz   (1000000),
    .p_baud     (100000),
    .p_data_bits(8),
    .p_tx_depth (4),
    .p_rx_depth (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_accept    (o_accept),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_accept    (i_accept),
    .i_rx        (i_rx),
    .o_tx        (o_tx),
    .i_loopback  (i_loopback),
    .o_busy      (o_busy),
    .o_rx_overrun(o_rx_overrun),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];
  int pop_cnt = 0, frame_cnt = 0, par_cnt = 0, ovr_cnt = 0, tx_low_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: count pulses and compare every delivered word against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_frame_err)  frame_cnt++;
      if (o_parity_err) par_cnt++;
      if (o_rx_overrun) ovr_cnt++;
      if (!o_tx)        tx_low_cnt++;
      if (o_valid && i_accept) begin
        pop_cnt++;
        if (sb_q.size() == 0) check_eq("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
        else check_eq("sb_rx_word", 32'(o_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic [7:0] d, input bit expect_rx);
    int t = 0;
    i_data  = d;
    i_valid = 1'b1;
    while (!o_accept && t < 1000) begin tick(); t++; end
    check_eq("push_wait", 32'(t < 1000), 32'd1);
    if (expect_rx) sb_q.push_back(d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int t = 0;
    while (sb_q.size() != 0 && t < max) begin tick(); t++; end
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic send_bit(input logic b);
    rx_drv = b;
    idle(Div);
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (Pbit != 0) send_bit((^d) ^ par_flip);
    send_bit(stop);
    rx_drv = 1'b1;
    idle(2 * Div);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t;
    idle(3);
    check_eq("rst_tx", 32'(o_tx), 32'd1);
    check_eq("rst_accept", 32'(o_accept), 32'd1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    check_eq("rst_err", 32'({o_rx_overrun, o_frame_err, o_parity_err}), 32'd0);
    i_rst = 1'b0;
    idle(5);

    // Loopback single word
    i_loopback = 1'b1;
    tx_low_cnt = 0;
    i_data     = 8'hA5;
    i_valid    = 1'b1;
    check_eq("lb_accept", 32'(o_accept), 32'd1);
    sb_q.push_back(8'hA5);
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 400) begin tick(); lat++; end
    check_eq("lb_latency_in_window", 32'(lat >= Frame && lat <= Frame + 5), 32'd1);
    wait_drain(50);
    idle(30);
    check_eq("lb_tx_held_high", 32'(tx_low_cnt), 32'd0);

    // Back-to-back frames on the pad, looped externally
    i_loopback = 1'b0;
    ext_loop   = 1'b1;
    idle(5);
    i_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      i_data = 8'(k);
      check_eq("b2b_accept", 32'(o_accept), 32'd1);
      sb_q.push_back(8'(k));
      tick();
      if (k == 2) check_eq("b2b_tx_before_start", 32'(o_tx), 32'd1);
      if (k == 3) check_eq("b2b_tx_start_edge", 32'(o_tx), 32'd0);
    end
    i_valid = 1'b0;
    check_eq("b2b_full", 32'(o_accept), 32'd0);
    idle(Frame - 4);
    check_eq("b2b_still_full", 32'(o_accept), 32'd0);
    tick();
    check_eq("b2b_reaccept", 32'(o_accept), 32'd1);
    idle(4 * Frame - 1);
    check_eq("b2b_busy_last_stop", 32'(o_busy), 32'd1);
    tick();
    check_eq("b2b_idle_no_gap", 32'(o_busy), 32'd0);
    wait_drain(300);
    ext_loop = 1'b0;
    idle(30);

    // Overrun: RX FIFO full, fifth frame dropped
    i_loopback = 1'b1;
    i_accept   = 1'b0;
    ovr_cnt    = 0;
    pop_cnt    = 0;
    for (int k = 0; k < 5; k++) push_word(8'h11 + 8'(k), k < 4);
    t = 0;
    while (ovr_cnt == 0 && t < 2000) begin tick(); t++; end
    idle(5);
    check_eq("ovr_pulse_cycles", 32'(ovr_cnt), 32'd1);
    check_eq("ovr_head_word", 32'(o_data), 32'h11);
    check_eq("ovr_valid", 32'(o_valid), 32'd1);
    i_accept = 1'b1;
    wait_drain(50);
    idle(5);
    check_eq("ovr_pop_count", 32'(pop_cnt), 32'd4);
    check_eq("ovr_empty", 32'(o_valid), 32'd0);
    i_loopback = 1'b0;
    idle(30);

    // Frame error from the pad, then a good frame
    frame_cnt = 0;
    pop_cnt   = 0;
    drive_rx_frame(8'h3C, 1'b0, 1'b0);
    check_eq("ferr_pulse_cycles", 32'(frame_cnt), 32'd1);
    check_eq("ferr_no_word", 32'(pop_cnt), 32'd0);
    check_eq("ferr_valid_low", 32'(o_valid), 32'd0);
    sb_q.push_back(8'h55);
    drive_rx_frame(8'h55, 1'b1, 1'b0);
    wait_drain(100);
    check_eq("ferr_recover_pops", 32'(pop_cnt), 32'd1);

`ifdef X_TOP_UART_LINK_PARITY_EN
    par_cnt = 0;
    pop_cnt = 0;
    drive_rx_frame(8'h07, 1'b1, 1'b1);
    check_eq("perr_pulse_cycles", 32'(par_cnt), 32'd1);
    check_eq("perr_no_word", 32'(pop_cnt), 32'd0);
    sb_q.push_back(8'h07);
    drive_rx_frame(8'h07, 1'b1, 1'b0);
    wait_drain(100);
    check_eq("perr_good_pops", 32'(pop_cnt), 32'd1);
`else
    check_eq("perr_tied_low", 32'(par_cnt), 32'd0);
`endif

    // Reset in the middle of a TX frame
    ext_loop = 1'b1;
    idle(10);
    push_word(8'hFF, 1'b0);
    idle(30);
    check_eq("rstmid_busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    check_eq("rstmid_tx", 32'(o_tx), 32'd1);
    check_eq("rstmid_busy", 32'(o_busy), 32'd0);
    check_eq("rstmid_valid", 32'(o_valid), 32'd0);
    idle(3);
    i_rst = 1'b0;
    idle(5);
    pop_cnt = 0;
    push_word(8'h12, 1'b1);
    wait_drain(Frame + 50);
    idle(Frame + 20);
    check_eq("rstmid_only_new_word", 32'(pop_cnt), 32'd1);
    check_eq("rstmid_final_idle", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
